// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Front-end conditioner for board push-buttons. Each channel is synchronized,
//   debounced with a stable-level counter, and converted into one-cycle
//   press / release strobes. Press optionally auto-repeats while held.
//   Channels are independent and share only the clock and reset.
//
// Ports
//   clk         in   system clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   btn_raw_i   in   [N_BTN] raw asynchronous button pins, active-high
//   level_o     out  [N_BTN] debounced button level
//   press_o     out  [N_BTN] one-cycle strobe on accepted press / auto-repeat
//   release_o   out  [N_BTN] one-cycle strobe on accepted release
//   any_press_o out  OR of press_o, same cycle
//
// Note: the release output carries the _o suffix; a bare "release" would
// collide with the force/release keyword.
// -----------------------------------------------------------------------------

// Per-channel lane: synchronizer, debounce filter and repeat FSM.
module button_conditioner_lane #(
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic press_nxt_o,   // next-cycle press, lets the top register the OR
  output logic release_o
);

  localparam int DW   = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

  localparam logic [DW-1:0] STB_LAST  = DW'(STABLE_CYCLES - 1);
  // A zero delay never reaches HOLD_WAIT, so its terminal count is unused.
  localparam logic [RW-1:0] DLY_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST = RW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam bit            RPT_EN    = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HOLD_WAIT = 2'd1,
    S_REPEAT    = 2'd2,
    S_HELD      = 2'd3
  } rpt_state_e;

  logic          s1_q, s2_q;
  logic [DW-1:0] dbc_cnt_q, dbc_cnt_d;
  logic          level_q, level_d;
  logic          rise, fall;
  rpt_state_e    state_q, state_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Two-flop synchronizer; only s2_q is allowed to reach the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Debounce: count consecutive samples disagreeing with the accepted level.
  // Any agreeing sample clears the count, so short glitches never get through.
  always_comb begin
    dbc_cnt_d = '0;
    level_d   = level_q;
    rise      = 1'b0;
    fall      = 1'b0;
    if (s2_q != level_q) begin
      if (dbc_cnt_q == STB_LAST) begin
        level_d = s2_q;
        rise    = s2_q;
        fall    = ~s2_q;
      end else begin
        dbc_cnt_d = dbc_cnt_q + DW'(1);
      end
    end
  end

  // Repeat FSM. The release check sits ahead of the case so a repeat that
  // falls due on the release cycle is dropped and press/release never overlap.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (fall) begin
      state_d   = S_IDLE;
      rpt_cnt_d = '0;
      release_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            press_d   = 1'b1;
            rpt_cnt_d = '0;
            state_d   = RPT_EN ? S_HOLD_WAIT : S_HELD;
          end
        end
        S_HOLD_WAIT: begin
          if (rpt_cnt_q == DLY_LAST) begin
            press_d   = 1'b1;
            rpt_cnt_d = '0;
            state_d   = S_REPEAT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
          end
        end
        S_REPEAT: begin
          if (rpt_cnt_q == RATE_LAST) begin
            press_d   = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
          end
        end
        S_HELD: begin
          state_d = S_HELD;
        end
        default: begin
          state_d   = S_IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbc_cnt_q <= '0;
      level_q   <= 1'b0;
      state_q   <= S_IDLE;
      rpt_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      dbc_cnt_q <= dbc_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign press_nxt_o = press_d;
  assign release_o   = release_q;

endmodule

module button_conditioner #(
  parameter int N_BTN         = 3,
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic             any_press_o
);

  logic [N_BTN-1:0] press_nxt;
  logic             any_press_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    button_conditioner_lane #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_i       (btn_raw_i[i]),
      .level_o     (level_o[i]),
      .press_o     (press_o[i]),
      .press_nxt_o (press_nxt[i]),
      .release_o   (release_o[i])
    );
  end

  // Registered from the lanes' next-state so it lines up with press_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_press_q <= 1'b0;
    else        any_press_q <= |press_nxt;
  end

  assign any_press_o = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  localparam int N = 3;
  localparam int S = 4;
  localparam int D = 10;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
  logic         any_a, any_b;

  always #5 clk = ~clk;

  // dut: auto-repeat build; dut_nr: repeat disabled. Same inputs.
  button_conditioner #(.N_BTN(N), .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_raw),
    .level_o(lvl_a), .press_o(prs_a), .release_o(rel_a), .any_press_o(any_a));
  button_conditioner #(.N_BTN(N), .STABLE_CYCLES(S), .REPEAT_DELAY(0), .REPEAT_RATE(R)) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_raw),
    .level_o(lvl_b), .press_o(prs_b), .release_o(rel_b), .any_press_o(any_b));

  int ncmp = 0;
  int nfail = 0;

  // Reference model [build][channel]: raw delayed two samples, a run length of
  // samples disagreeing with the level, and repeats computed from the elapsed
  // time since the press.
  logic d1[2][N], d2[2][N], lv[2][N], ep[2][N], er[2][N], held[2][N];
  int   run[2][N], pt[2][N];
  int   t = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < N; c++) begin
        d1[m][c] = 0; d2[m][c] = 0; lv[m][c] = 0; ep[m][c] = 0; er[m][c] = 0;
        held[m][c] = 0; run[m][c] = 0; pt[m][c] = 0;
      end
  endtask

  task automatic model_step();
    logic samp;
    int   e, dly;
    if (!rst_n) begin
      model_reset();
      return;
    end
    t++;
    for (int m = 0; m < 2; m++) begin
      dly = (m == 0) ? D : 0;
      for (int c = 0; c < N; c++) begin
        samp = d2[m][c];
        d2[m][c] = d1[m][c];
        d1[m][c] = btn_raw[c];
        ep[m][c] = 0;
        er[m][c] = 0;
        if (samp != lv[m][c]) begin
          run[m][c]++;
          if (run[m][c] == S) begin
            lv[m][c] = samp;
            run[m][c] = 0;
            if (samp) begin ep[m][c] = 1; pt[m][c] = t; held[m][c] = 1; end
            else      begin er[m][c] = 1; held[m][c] = 0; end
          end
        end else begin
          run[m][c] = 0;
        end
        if (!ep[m][c] && !er[m][c] && held[m][c] && dly != 0) begin
          e = t - pt[m][c];
          if (e == dly || (e > dly && (e - dly) % R == 0)) ep[m][c] = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s @t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] el[2], epv[2], erv[2];
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < N; c++) begin
        el[m][c] = lv[m][c]; epv[m][c] = ep[m][c]; erv[m][c] = er[m][c];
      end
    check("level_a", 32'(lvl_a), 32'(el[0]));
    check("press_a", 32'(prs_a), 32'(epv[0]));
    check("release_a", 32'(rel_a), 32'(erv[0]));
    check("any_a", 32'(any_a), 32'(|epv[0]));
    check("level_b", 32'(lvl_b), 32'(el[1]));
    check("press_b", 32'(prs_b), 32'(epv[1]));
    check("release_b", 32'(rel_b), 32'(erv[1]));
    check("any_b", 32'(any_b), 32'(|epv[1]));
  endtask

  // Drive at the falling edge, let the DUT and model step on the rising edge,
  // compare at the next falling edge.
  task automatic tick(input logic [N-1:0] b);
    btn_raw = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int np, nr, nl;
    logic [N-1:0] cur;
    model_reset();

    // Reset held with all buttons pressed: everything stays 0.
    for (int i = 0; i < 3; i++) tick(3'b111);
    check("rst_level", 32'(lvl_a), 0);
    rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 8; i++) begin
      tick(3'b111);
      if (prs_a == 3'b111) begin
        np++;
        check("rst_press_latency", i, 5);
      end
    end
    check("rst_single_press", np, 1);
    check("rst_level_up", 32'(lvl_a), 32'(3'b111));
    for (int i = 0; i < 12; i++) tick(3'b000);

    // Glitch of 3 cycles is rejected; 4 cycles is accepted once.
    nl = 0;
    for (int i = 0; i < 14; i++) begin
      tick((i < 3) ? 3'b001 : 3'b000);
      if (lvl_a[0] || prs_a[0]) nl++;
    end
    check("glitch_rejected", nl, 0);
    np = 0;
    for (int i = 0; i < 14; i++) begin
      tick((i < 4) ? 3'b001 : 3'b000);
      if (prs_a[0]) np++;
    end
    check("pulse4_press", np, 1);

    // Clean press/release on ch1, repeat-disabled build.
    np = 0; nr = 0;
    for (int i = 0; i < 24; i++) begin
      tick((i < 13) ? 3'b010 : 3'b000);
      if (prs_b[1]) np++;
      if (rel_b[1]) nr++;
    end
    check("norpt_press_cnt", np, 1);
    check("norpt_release_cnt", nr, 1);
    check("norpt_level_low", 32'(lvl_b[1]), 0);

    // Auto-repeat on ch2: press at P=5, repeats at 15,20,25,30,35.
    np = 0; nr = 0;
    for (int i = 0; i < 50; i++) begin
      tick((i < 33) ? 3'b100 : 3'b000);
      if (prs_a[2]) np++;
      if (rel_a[2]) nr++;
      if (i == 35) check("rpt_last_at_P30", 32'(prs_a[2]), 1);
    end
    check("rpt_press_cnt", np, 6);
    check("rpt_release_cnt", nr, 1);

    // Release lands exactly on the first repeat slot (P+10).
    np = 0;
    for (int i = 0; i < 30; i++) begin
      tick((i < 10) ? 3'b100 : 3'b000);
      if (i == 15) begin
        check("race_release", 32'(rel_a[2]), 1);
        check("race_press_supp", 32'(prs_a[2]), 0);
      end
      if (i > 15 && prs_a[2]) np++;
    end
    check("race_idle_after", np, 0);

    // Reset during HOLD_WAIT: outputs clear immediately, nothing pending.
    for (int i = 0; i < 8; i++) tick(3'b100);
    btn_raw = 3'b000;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_level", 32'(lvl_a), 0);
    check("midrst_press", 32'(prs_a), 0);
    check("midrst_release", 32'(rel_a), 0);
    tick(3'b000);
    tick(3'b000);
    rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 25; i++) begin
      tick(3'b000);
      if (prs_a != 0 || rel_a != 0) np++;
    end
    check("midrst_no_strobe", np, 0);

    // Simultaneous presses on ch0 and ch2.
    np = 0;
    for (int i = 0; i < 22; i++) begin
      tick((i < 8) ? 3'b101 : 3'b000);
      if (prs_a == 3'b101 && any_a) np++;
    end
    check("simul_press", np, 1);

    // Randomized bouncing, checked cycle by cycle against the model.
    cur = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(5) == 0) cur[c] = ~cur[c];
      tick(cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
